palette_ctrl: RTL and testbench

PALETTE_CTRL -- requirements
Module: palette_ctrl

---
 rtl/palette_ctrl_if.sv | 22 ++
 rtl/palette_ctrl.sv | 163 ++++++++++++++++
 tb/tb_palette_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/palette_ctrl_if.sv
// CPU-side palette bus: one entry per cycle, writes and reads always target the back bank.
interface palette_ctrl_if #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned CH_BITS   = 4
);
  localparam int unsigned W = 3 * CH_BITS;

  logic [ADDR_BITS-1:0] bus_addr;
  logic [W-1:0]         bus_wrdata;
  logic                 bus_wren;
  logic [W-1:0]         bus_rddata;

  modport master (
    output bus_addr, bus_wrdata, bus_wren,
    input  bus_rddata
  );

  modport slave (
    input  bus_addr, bus_wrdata, bus_wren,
    output bus_rddata
  );
endinterface

// File: rtl/palette_ctrl.sv
// Double-buffered colour palette with vsync-synchronised bank swap and a
// frame-paced brightness fade applied on the video lookup path.
module palette_ctrl #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned CH_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  palette_ctrl_if.slave        bus,
  input  logic                 swap_req,
  output logic                 swap_pending,
  input  logic                 vsync,
  input  logic                 fade_wr,
  input  logic [CH_BITS-1:0]   fade_target,
  input  logic [3:0]           fade_rate,
  output logic                 fade_busy,
  output logic [CH_BITS-1:0]   brightness,
  input  logic [ADDR_BITS-1:0] palidx,
  output logic [CH_BITS-1:0]   pal_r,
  output logic [CH_BITS-1:0]   pal_g,
  output logic [CH_BITS-1:0]   pal_b
);

  localparam int unsigned W     = 3 * CH_BITS;
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PW    = 2 * CH_BITS + 1;
  localparam logic [CH_BITS-1:0] B_MAX = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  // Both banks live in one array; the MSB of the index is the bank select.
  logic [W-1:0]         r_mem [2*DEPTH];
  logic [ADDR_BITS:0]   w_back_addr;
  logic [ADDR_BITS:0]   w_front_addr;

  logic [W-1:0]         r_rddata;
  logic [W-1:0]         r_s1_pix;
  logic [CH_BITS-1:0]   r_s1_bright;
  logic [CH_BITS-1:0]   r_pal_r, r_pal_g, r_pal_b;

  state_t               r_state, w_state;
  logic                 r_front_bank, w_front_bank;
  logic                 r_swap_pending, w_swap_pending;
  logic [CH_BITS-1:0]   r_bright, w_bright;
  logic [CH_BITS-1:0]   r_target, w_target;
  logic [3:0]           r_rate, w_rate;
  logic [3:0]           r_cnt, w_cnt;
  logic [CH_BITS-1:0]   w_step;

  assign w_back_addr  = {~r_front_bank, bus.bus_addr};
  assign w_front_addr = {r_front_bank, palidx};

  function automatic logic [CH_BITS-1:0] scale_ch(input logic [CH_BITS-1:0] c,
                                                  input logic [CH_BITS-1:0] b);
    logic [PW-1:0] p;
    p = PW'(c) * (PW'(b) + PW'(1));
    return CH_BITS'(p >> CH_BITS);
  endfunction

  // Palette storage: deliberately unreset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (bus.bus_wren) r_mem[w_back_addr] <= bus.bus_wrdata;
  end

  // CPU readback and the two-stage video pipeline; brightness travels with the
  // pixel so a swap and a fade step on the same vsync hit the same pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rddata    <= '0;
      r_s1_pix    <= '0;
      r_s1_bright <= '0;
      r_pal_r     <= '0;
      r_pal_g     <= '0;
      r_pal_b     <= '0;
    end else begin
      r_rddata    <= r_mem[w_back_addr];
      r_s1_pix    <= r_mem[w_front_addr];
      r_s1_bright <= r_bright;
      r_pal_r     <= scale_ch(r_s1_pix[W-1 -: CH_BITS], r_s1_bright);
      r_pal_g     <= scale_ch(r_s1_pix[2*CH_BITS-1 -: CH_BITS], r_s1_bright);
      r_pal_b     <= scale_ch(r_s1_pix[CH_BITS-1:0], r_s1_bright);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
      r_bright       <= B_MAX;
      r_target       <= B_MAX;
      r_rate         <= '0;
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state;
      r_front_bank   <= w_front_bank;
      r_swap_pending <= w_swap_pending;
      r_bright       <= w_bright;
      r_target       <= w_target;
      r_rate         <= w_rate;
      r_cnt          <= w_cnt;
    end
  end

  // Next-state: bank swap handshake and fade FSM.
  always_comb begin
    w_state        = r_state;
    w_front_bank   = r_front_bank;
    w_swap_pending = r_swap_pending;
    w_bright       = r_bright;
    w_target       = r_target;
    w_rate         = r_rate;
    w_cnt          = r_cnt;
    w_step         = r_bright;

    if (r_target > r_bright) begin
      if (r_bright != B_MAX) w_step = r_bright + CH_BITS'(1);
    end else if (r_target < r_bright) begin
      if (r_bright != '0) w_step = r_bright - CH_BITS'(1);
    end

    if (vsync && (r_swap_pending || swap_req)) begin
      w_front_bank   = ~r_front_bank;
      w_swap_pending = 1'b0;
    end else if (swap_req) begin
      w_swap_pending = 1'b1;
    end

    if (fade_wr) begin
      w_target = fade_target;
      w_rate   = fade_rate;
      w_cnt    = '0;
      w_state  = (fade_target != r_bright) ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state = ST_IDLE;
        ST_RUN: begin
          if (vsync) begin
            if (r_rate == 4'd0) begin
              w_bright = r_target;
            end else if (r_cnt >= r_rate) begin
              w_bright = w_step;
              w_cnt    = '0;
            end else begin
              w_cnt = r_cnt + 4'd1;
            end
            if (w_bright == r_target) w_state = ST_IDLE;
          end
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  assign bus.bus_rddata = r_rddata;
  assign swap_pending   = r_swap_pending;
  assign fade_busy      = (r_state == ST_RUN);
  assign brightness     = r_bright;
  assign pal_r          = r_pal_r;
  assign pal_g          = r_pal_g;
  assign pal_b          = r_pal_b;

endmodule

// File: tb/tb_palette_ctrl.sv
// Scoreboard bench for palette_ctrl: a frame-level reference model queues
// expected outputs per clock edge, a negedge monitor pops and compares them.
module tb_palette_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 4;

  typedef struct {
    int          due;
    logic [11:0] v;
  } exp_t;

  logic clk;
  logic reset_n;
  logic swap_req, vsync, fade_wr;
  logic [3:0] fade_target, fade_rate;
  logic [5:0] palidx;
  logic swap_pending, fade_busy;
  logic [3:0] brightness, pal_r, pal_g, pal_b;

  palette_ctrl_if #(.ADDR_BITS(AW), .CH_BITS(CW)) bus ();

  palette_ctrl #(.ADDR_BITS(AW), .CH_BITS(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .vsync        (vsync),
    .fade_wr      (fade_wr),
    .fade_target  (fade_target),
    .fade_rate    (fade_rate),
    .fade_busy    (fade_busy),
    .brightness   (brightness),
    .palidx       (palidx),
    .pal_r        (pal_r),
    .pal_g        (pal_g),
    .pal_b        (pal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  bit run_chk = 1'b1;

  always @(posedge clk) edge_cnt++;

  exp_t q_rd[$];
  exp_t q_pal[$];
  exp_t q_ctl[$];

  // Reference model state
  logic [11:0] m_bank [2][64];
  int m_front, m_pend, m_busy, m_bright, m_tgt, m_rate, m_cnt;

  // Stimulus for the next cycle; pulses clear after each cycle
  logic        s_wren;
  logic [5:0]  s_addr;
  logic [11:0] s_wd;
  logic        s_sreq, s_vs, s_fwr;
  logic [3:0]  s_ft, s_fr;
  logic [5:0]  s_pidx;
  bit          s_chk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [11:0] scale(input logic [11:0] c, input int b);
    int r, g, bl;
    r  = int'(c[11:8]) * (b + 1) / 16;
    g  = int'(c[7:4])  * (b + 1) / 16;
    bl = int'(c[3:0])  * (b + 1) / 16;
    return {4'(r), 4'(g), 4'(bl)};
  endfunction

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_busy = 0;
    m_bright = 15; m_tgt = 15; m_rate = 0; m_cnt = 0;
  endtask

  // Apply one cycle of stimulus and predict its effect on the following edges.
  task automatic cyc();
    int ed;
    int bk;
    logic [11:0] rd, pix;
    int b;
    @(posedge clk);
    #1;
    bus.bus_wren   = s_wren;
    bus.bus_addr   = s_addr;
    bus.bus_wrdata = s_wd;
    swap_req       = s_sreq;
    vsync          = s_vs;
    fade_wr        = s_fwr;
    fade_target    = s_ft;
    fade_rate      = s_fr;
    palidx         = s_pidx;

    ed  = edge_cnt;
    bk  = 1 - m_front;
    rd  = m_bank[bk][s_addr];
    pix = m_bank[m_front][s_pidx];
    b   = m_bright;
    if (s_chk) begin
      q_rd.push_back('{ed + 1, rd});
      q_pal.push_back('{ed + 2, scale(pix, b)});
    end

    if (s_wren) m_bank[bk][s_addr] = s_wd;

    if (s_vs && (m_pend != 0 || s_sreq)) begin
      m_front = 1 - m_front;
      m_pend  = 0;
    end else if (s_sreq) begin
      m_pend = 1;
    end

    if (s_fwr) begin
      m_tgt  = int'(s_ft);
      m_rate = int'(s_fr);
      m_cnt  = 0;
      m_busy = (m_tgt != m_bright) ? 1 : 0;
    end else if (m_busy != 0 && s_vs) begin
      if (m_rate == 0) begin
        m_bright = m_tgt;
      end else if (m_cnt >= m_rate) begin
        m_bright = (m_tgt > m_bright) ? m_bright + 1 : m_bright - 1;
        if (m_bright > 15) m_bright = 15;
        if (m_bright < 0)  m_bright = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_busy = (m_bright != m_tgt) ? 1 : 0;
    end

    if (s_chk) q_ctl.push_back('{ed + 1, 12'({m_pend[0], m_busy[0], 4'(m_bright)})});

    s_wren = 1'b0; s_sreq = 1'b0; s_vs = 1'b0; s_fwr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rddata"},  bus.bus_rddata, 12'h000);
    check({tag, "_pal"},     {pal_r, pal_g, pal_b}, 12'h000);
    check({tag, "_pending"}, 12'(swap_pending), 12'h000);
    check({tag, "_busy"},    12'(fade_busy), 12'h000);
    check({tag, "_bright"},  12'(brightness), 12'h00F);
  endtask

  // Monitor: compare every expectation whose edge has arrived
  always @(negedge clk) begin
    exp_t e;
    if (run_chk) begin
      while (q_rd.size() > 0 && q_rd[0].due <= edge_cnt) begin
        e = q_rd.pop_front();
        if (e.due == edge_cnt) check("bus_rddata", bus.bus_rddata, e.v);
        else check("stale_rd", 12'hFFF, e.v);
      end
      while (q_pal.size() > 0 && q_pal[0].due <= edge_cnt) begin
        e = q_pal.pop_front();
        if (e.due == edge_cnt) check("pal_rgb", {pal_r, pal_g, pal_b}, e.v);
        else check("stale_pal", 12'hFFF, e.v);
      end
      while (q_ctl.size() > 0 && q_ctl[0].due <= edge_cnt) begin
        e = q_ctl.pop_front();
        if (e.due == edge_cnt)
          check("ctl{pend,busy,bright}", 12'({swap_pending, fade_busy, brightness}), e.v);
        else check("stale_ctl", 12'hFFF, e.v);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++) m_bank[k][a] = 12'h000;
    model_reset();
    s_wren = 0; s_addr = 0; s_wd = 0; s_sreq = 0; s_vs = 0; s_fwr = 0;
    s_ft = 0; s_fr = 0; s_pidx = 0; s_chk = 0;
    bus.bus_wren = 0; bus.bus_addr = 0; bus.bus_wrdata = 0;
    swap_req = 0; vsync = 0; fade_wr = 0; fade_target = 0; fade_rate = 0; palidx = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;

    // Clear both banks so the model and RAM agree regardless of power-up state
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 64; a++) begin
        s_wren = 1; s_addr = 6'(a); s_wd = 12'h000; cyc();
      end
      s_sreq = 1; s_vs = 1; cyc();
    end
    idle(3);
    s_chk = 1;

    // Write back[5], swap, look it up; old bank reads back as zero
    s_wren = 1; s_addr = 6'd5; s_wd = 12'hF11; cyc();
    s_sreq = 1; cyc();
    s_vs = 1; cyc();
    s_pidx = 6'd5; s_addr = 6'd5; idle(4);

    // Long pending swap without vsync, then complete
    s_sreq = 1; cyc();
    idle(100);
    s_vs = 1; cyc();
    idle(3);

    // Colours for the fade and scaling checks, then bring them to the front
    s_wren = 1; s_addr = 6'd9;  s_wd = 12'h8F4; cyc();
    s_wren = 1; s_addr = 6'd12; s_wd = 12'hFFF; cyc();
    s_sreq = 1; s_vs = 1; cyc();
    s_pidx = 6'd9; idle(2);

    // Fade 15 -> 0 at rate 1, vsync every other cycle
    s_fwr = 1; s_ft = 4'd0; s_fr = 4'd1; cyc();
    for (int i = 0; i < 34; i++) begin
      s_vs = 1; cyc(); cyc();
    end
    idle(3);

    // Scaling at brightness 7 and 15 on a full-scale entry
    s_pidx = 6'd12;
    s_fwr = 1; s_ft = 4'd7; s_fr = 4'd0; cyc();
    s_vs = 1; cyc();
    idle(3);
    s_fwr = 1; s_ft = 4'd15; s_fr = 4'd0; cyc();
    s_vs = 1; cyc();
    idle(3);

    // Load and vsync together: load wins; then an equal-target load
    s_fwr = 1; s_vs = 1; s_ft = 4'd3; s_fr = 4'd0; cyc();
    idle(2);
    s_vs = 1; cyc();
    idle(2);
    s_fwr = 1; s_ft = 4'd3; s_fr = 4'd2; cyc();
    s_vs = 1; cyc();
    idle(2);

    // Mid-fade with a swap pending, then asynchronous reset
    s_fwr = 1; s_ft = 4'd15; s_fr = 4'd2; cyc();
    for (int i = 0; i < 4; i++) begin
      s_vs = 1; cyc();
    end
    s_sreq = 1; cyc();
    idle(3);
    @(posedge clk);
    #3;
    run_chk = 1'b0;
    q_rd.delete(); q_pal.delete(); q_ctl.delete();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #10;
    reset_n = 1'b1;
    model_reset();
    run_chk = 1'b1;

    // Contents survive reset on both ports
    for (int a = 0; a < 16; a++) begin
      s_addr = 6'(a); s_pidx = 6'(15 - a); cyc();
    end
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      s_wren = ($urandom_range(1) == 1);
      s_addr = 6'($urandom_range(63));
      s_wd   = 12'($urandom_range(4095));
      s_sreq = ($urandom_range(7) == 0);
      s_vs   = ($urandom_range(5) == 0);
      s_fwr  = ($urandom_range(19) == 0);
      s_ft   = 4'($urandom_range(15));
      s_fr   = 4'($urandom_range(3));
      s_pidx = 6'($urandom_range(63));
      cyc();
    end
    idle(4);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
